// File: rtl/l2_lookup_sched.sv
// L2 lookup scheduler: arbitrates core requests vs. forwards, sequences the tag/state RAM read,
// pulses l2_lookup and holds the result handshake. Optional stats under L2_LOOKUP_SCHED_STATS_EN.
module l2_lookup_sched #(
    parameter int SET_BITS       = 9,
    parameter int RD_LAT         = 1,
    parameter int MAX_FWD_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [SET_BITS-1:0] req_set,
    output logic                req_ready,
    input  logic                fwd_valid,
    input  logic [SET_BITS-1:0] fwd_set,
    output logic                fwd_ready,
    output logic                rd_en,
    output logic [SET_BITS-1:0] rd_set,
    output logic                lookup_en,
    output logic                lookup_mode,
    output logic                res_valid,
    output logic                res_is_fwd,
    input  logic                res_ready,
    output logic                busy,
`ifdef L2_LOOKUP_SCHED_STATS_EN
    output logic [15:0]         stat_req_cnt,
    output logic [15:0]         stat_fwd_cnt,
`endif
    output logic [2:0]          dbg_state
);

    localparam int CNT_W    = $clog2(RD_LAT + 1);
    localparam int STREAK_W = $clog2(MAX_FWD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_FWD_STREAK);
    localparam logic LOOKUP_REQ = 1'b0;
    localparam logic LOOKUP_FWD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_LKP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [SET_BITS-1:0]   r_set;
    logic                  r_is_fwd;
    logic [STREAK_W-1:0]   r_streak;
    logic [CNT_W-1:0]      r_cnt;

    logic w_idle;
    logic w_fwd_win;
    logic w_fwd_acc;
    logic w_req_acc;

    // Handshakes: a transfer happens in a cycle where valid && ready; the source holds valid (and
    // its payload) until it sees ready. res_valid is held stable until res_ready is seen with it.
    assign w_idle    = (r_state == S_IDLE);
    assign w_fwd_win = fwd_valid && (!req_valid || (r_streak < STREAK_MAX));
    assign fwd_ready = w_idle && !rst && w_fwd_win;
    assign req_ready = w_idle && !rst && req_valid && !w_fwd_win;
    assign w_fwd_acc = fwd_valid && fwd_ready;
    assign w_req_acc = req_valid && req_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_fwd_acc || w_req_acc) w_next = S_RD;
            S_RD:   w_next = (RD_LAT == 1) ? S_LKP : S_WAIT;
            S_WAIT: if (r_cnt == CNT_W'(1)) w_next = S_LKP;
            S_LKP:  w_next = S_RESP;
            S_RESP: if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_set    <= '0;
            r_is_fwd <= 1'b0;
            r_streak <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_fwd_acc || w_req_acc) begin
                r_set    <= w_fwd_acc ? fwd_set : req_set;
                r_is_fwd <= w_fwd_acc;
            end
            // Streak only grows while a request is actually being passed over.
            if (w_req_acc) begin
                r_streak <= '0;
            end else if (w_fwd_acc) begin
                if (!req_valid)
                    r_streak <= '0;
                else if (r_streak < STREAK_MAX)
                    r_streak <= r_streak + STREAK_W'(1);
            end
            if (r_state == S_RD)
                r_cnt <= CNT_W'(RD_LAT - 1);
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign rd_en       = (r_state == S_RD);
    assign rd_set      = r_set;
    assign lookup_en   = (r_state == S_LKP);
    assign lookup_mode = lookup_en ? (r_is_fwd ? LOOKUP_FWD : LOOKUP_REQ) : 1'b0;
    assign res_valid   = (r_state == S_RESP);
    assign res_is_fwd  = res_valid && r_is_fwd;
    assign busy        = !w_idle;
    assign dbg_state   = r_state;

`ifdef L2_LOOKUP_SCHED_STATS_EN
    logic [15:0] r_stat_req;
    logic [15:0] r_stat_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_req <= '0;
            r_stat_fwd <= '0;
        end else begin
            if (w_req_acc && (r_stat_req != 16'hFFFF)) r_stat_req <= r_stat_req + 16'd1;
            if (w_fwd_acc && (r_stat_fwd != 16'hFFFF)) r_stat_fwd <= r_stat_fwd + 16'd1;
        end
    end

    assign stat_req_cnt = r_stat_req;
    assign stat_fwd_cnt = r_stat_fwd;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
